// File: rtl/snes_poll_scheduler.sv
// Dual SNES controller poller: shared latch/clock, parallel serial capture,
// per-frame publication of button words, presence flags and sticky press events.
module snes_poll_scheduler #(
    parameter int TICK_DIV     = 300,
    parameter int FRAME_CYCLES = 833333
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        poll_now,
    input  logic        clear_events,
    input  logic        serial_data0,
    input  logic        serial_data1,
    output logic        snes_clk,
    output logic        data_latch,
    output logic        busy,
    output logic        frame_done,
    output logic [11:0] buttons0,
    output logic [11:0] buttons1,
    output logic        present0,
    output logic        present1,
    output logic [11:0] pressed0,
    output logic [11:0] pressed1
);

    localparam int TW = $clog2(2 * TICK_DIV);
    localparam int FW = $clog2(FRAME_CYCLES);

    localparam logic [TW-1:0] LATCH_LAST = TW'(2 * TICK_DIV - 1);
    localparam logic [TW-1:0] HALF_LAST  = TW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LATCH    = 3'd1;
    localparam logic [2:0] CLK_LOW  = 3'd2;
    localparam logic [2:0] CLK_HIGH = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    logic [2:0]    state;
    logic [TW-1:0] tick;
    logic [4:0]    bit_idx;
    logic [FW-1:0] frame_cnt;
    logic [15:0]   shift0;
    logic [15:0]   shift1;
    logic          auto_trig;
    logic          trigger;
    logic          tick_end;
    logic          present0_new;
    logic          present1_new;
    logic [11:0]   buttons0_new;
    logic [11:0]   buttons1_new;

    assign auto_trig  = enable && (frame_cnt == FRAME_LAST);
    assign trigger    = auto_trig || poll_now;
    assign snes_clk   = (state != CLK_LOW);
    assign data_latch = (state == LATCH);
    assign busy       = (state != IDLE);

    // Upper four bits of a real pad always shift out high; a floating or
    // missing pad reads low here.
    assign present0_new = &shift0[15:12];
    assign present1_new = &shift1[15:12];
    assign buttons0_new = present0_new ? ~shift0[11:0] : 12'h000;
    assign buttons1_new = present1_new ? ~shift1[11:0] : 12'h000;

    always_comb begin
        tick_end = 1'b0;
        case (state)
            LATCH:            tick_end = (tick == LATCH_LAST);
            CLK_LOW, CLK_HIGH: tick_end = (tick == HALF_LAST);
            default:          tick_end = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            frame_cnt <= '0;
        end else if (frame_cnt == FRAME_LAST) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tick    <= '0;
            bit_idx <= '0;
            shift0  <= '0;
            shift1  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state <= LATCH;
                        tick  <= '0;
                    end
                end
                LATCH: begin
                    if (tick_end) begin
                        state   <= CLK_LOW;
                        tick    <= '0;
                        bit_idx <= '0;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                CLK_LOW: begin
                    if (tick_end) begin
                        shift0[bit_idx[3:0]] <= serial_data0;
                        shift1[bit_idx[3:0]] <= serial_data1;
                        state <= CLK_HIGH;
                        tick  <= '0;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                CLK_HIGH: begin
                    if (tick_end) begin
                        tick    <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        state   <= (bit_idx == 5'd15) ? DONE : CLK_LOW;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A clear landing on the publish edge drops old events but keeps new edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
            buttons0   <= '0;
            buttons1   <= '0;
            present0   <= 1'b0;
            present1   <= 1'b0;
            pressed0   <= '0;
            pressed1   <= '0;
        end else begin
            frame_done <= (state == DONE);
            if (state == DONE) begin
                buttons0 <= buttons0_new;
                buttons1 <= buttons1_new;
                present0 <= present0_new;
                present1 <= present1_new;
                pressed0 <= (pressed0 & ~{12{clear_events}})
                          | (buttons0_new & ~buttons0);
                pressed1 <= (pressed1 & ~{12{clear_events}})
                          | (buttons1_new & ~buttons1);
            end else if (clear_events) begin
                pressed0 <= '0;
                pressed1 <= '0;
            end
        end
    end

endmodule
